// File: rtl/placement_request_sequencer.sv
// placement_request_sequencer
// Front-end driver for the sticker-placement core. Buffers upstream
// placement requests, feeds them to the core once per issue slot, and pairs
// each core result with the request that produced it. Responses appear a
// fixed number of slots after the request is issued.

module placement_request_sequencer #(
  parameter int DIM_W       = 5,
  parameter int IDX_W       = 8,
  parameter int STRIKE_W    = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int SLOT_CYCLES = 4,
  parameter int LAT_SLOTS   = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           req_valid_i,
  output logic                           req_ready_o,
  input  logic [DIM_W-1:0]               req_height_i,
  input  logic [DIM_W-1:0]               req_width_i,
  output logic [DIM_W-1:0]               height_o,
  output logic [DIM_W-1:0]               width_o,
  input  logic [IDX_W-1:0]               index_x_i,
  input  logic [IDX_W-1:0]               index_y_i,
  input  logic [STRIKE_W-1:0]            strike_i,
  output logic                           rsp_valid_o,
  output logic [DIM_W-1:0]               rsp_height_o,
  output logic [DIM_W-1:0]               rsp_width_o,
  output logic [IDX_W-1:0]               rsp_index_x_o,
  output logic [IDX_W-1:0]               rsp_index_y_o,
  output logic                           rsp_strike_o,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count_o
);

  // FIFO_DEPTH is a power of two (at least 2), so pointers wrap naturally.
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

  logic [SLOT_W-1:0] slot_cnt;
  logic              issue;

  logic [DIM_W-1:0]  fifo_h [FIFO_DEPTH];
  logic [DIM_W-1:0]  fifo_w [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;

  logic              push_accept;
  logic              push_write;
  logic              pop;
  logic [DIM_W-1:0]  head_h;
  logic [DIM_W-1:0]  head_w;

  logic              tag_v [LAT_SLOTS];
  logic [DIM_W-1:0]  tag_h [LAT_SLOTS];
  logic [DIM_W-1:0]  tag_w [LAT_SLOTS];

  logic [STRIKE_W-1:0] strike_prev;

  // An issue edge is the edge on which the slot counter wraps.
  assign issue = (slot_cnt == SLOT_W'(SLOT_CYCLES - 1));

  // Ready comes from the registered count only, so a full buffer refuses a
  // push even on an edge where it also pops; held low while in reset.
  assign req_ready_o = !rst_i && (fifo_count < CNT_W'(FIFO_DEPTH));

  // Zero-height or zero-width requests are consumed but never stored.
  assign push_accept = req_valid_i && req_ready_o;
  assign push_write  = push_accept && (req_height_i != '0) && (req_width_i != '0);
  assign pop         = issue && (fifo_count != '0);

  assign head_h = fifo_h[rd_ptr];
  assign head_w = fifo_w[rd_ptr];

  assign fifo_count_o = fifo_count;

  // Free-running slot counter that restarts from 0 at reset release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_cnt <= '0;
    end else if (issue) begin
      slot_cnt <= '0;
    end else begin
      slot_cnt <= slot_cnt + SLOT_W'(1);
    end
  end

  // Request buffer storage, pointers and occupancy count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_h[i] <= '0;
        fifo_w[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_write) begin
        fifo_h[wr_ptr] <= req_height_i;
        fifo_w[wr_ptr] <= req_width_i;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_write, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Drive the core inputs for a whole slot; an empty buffer issues the 0/0 no-op.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      height_o <= '0;
      width_o  <= '0;
    end else if (issue) begin
      height_o <= pop ? head_h : '0;
      width_o  <= pop ? head_w : '0;
    end
  end

  // Tag shift register that follows each issued piece through the core latency.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < LAT_SLOTS; i++) begin
        tag_v[i] <= 1'b0;
        tag_h[i] <= '0;
        tag_w[i] <= '0;
      end
    end else if (issue) begin
      tag_v[0] <= pop;
      tag_h[0] <= pop ? head_h : '0;
      tag_w[0] <= pop ? head_w : '0;
      for (int i = 1; i < LAT_SLOTS; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_h[i] <= tag_h[i-1];
        tag_w[i] <= tag_w[i-1];
      end
    end
  end

  // Capture the core result for the tag leaving the pipeline; bubbles leave rsp data untouched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_o   <= 1'b0;
      rsp_height_o  <= '0;
      rsp_width_o   <= '0;
      rsp_index_x_o <= '0;
      rsp_index_y_o <= '0;
      rsp_strike_o  <= 1'b0;
      strike_prev   <= '0;
    end else begin
      rsp_valid_o <= 1'b0;
      if (issue) begin
        strike_prev <= strike_i;
        if (tag_v[LAT_SLOTS-1]) begin
          rsp_valid_o   <= 1'b1;
          rsp_height_o  <= tag_h[LAT_SLOTS-1];
          rsp_width_o   <= tag_w[LAT_SLOTS-1];
          rsp_index_x_o <= index_x_i;
          rsp_index_y_o <= index_y_i;
          rsp_strike_o  <= (strike_i != strike_prev);
        end
      end
    end
  end

endmodule

// File: tb/tb_placement_request_sequencer.sv
// Testbench for placement_request_sequencer.
// Directed scenarios followed by a randomized phase, all compared against a
// queue-based reference model that tracks requests by edge number.

module tb_placement_request_sequencer;

  localparam int DIM_W       = 5;
  localparam int IDX_W       = 8;
  localparam int STRIKE_W    = 4;
  localparam int FIFO_DEPTH  = 4;
  localparam int SLOT_CYCLES = 4;
  localparam int LAT_SLOTS   = 2;

  logic                clk;
  logic                rst;
  logic                req_valid;
  logic                req_ready;
  logic [DIM_W-1:0]    req_height;
  logic [DIM_W-1:0]    req_width;
  logic [DIM_W-1:0]    height;
  logic [DIM_W-1:0]    width;
  logic [IDX_W-1:0]    index_x;
  logic [IDX_W-1:0]    index_y;
  logic [STRIKE_W-1:0] strike;
  logic                rsp_valid;
  logic [DIM_W-1:0]    rsp_height;
  logic [DIM_W-1:0]    rsp_width;
  logic [IDX_W-1:0]    rsp_index_x;
  logic [IDX_W-1:0]    rsp_index_y;
  logic                rsp_strike;
  logic [2:0]          fifo_count;

  placement_request_sequencer #(
    .DIM_W(DIM_W), .IDX_W(IDX_W), .STRIKE_W(STRIKE_W),
    .FIFO_DEPTH(FIFO_DEPTH), .SLOT_CYCLES(SLOT_CYCLES), .LAT_SLOTS(LAT_SLOTS)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_height_i(req_height), .req_width_i(req_width),
    .height_o(height), .width_o(width),
    .index_x_i(index_x), .index_y_i(index_y), .strike_i(strike),
    .rsp_valid_o(rsp_valid), .rsp_height_o(rsp_height), .rsp_width_o(rsp_width),
    .rsp_index_x_o(rsp_index_x), .rsp_index_y_o(rsp_index_y),
    .rsp_strike_o(rsp_strike), .fifo_count_o(fifo_count)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [DIM_W-1:0] h;
    logic [DIM_W-1:0] w;
  } req_t;

  typedef struct {
    int               due;
    logic [DIM_W-1:0] h;
    logic [DIM_W-1:0] w;
  } flight_t;

  req_t    fifo_q[$];
  flight_t flight_q[$];

  int                  checks = 0;
  int                  errors = 0;
  int                  edge_n = 0;
  bit                  last_acc;
  logic [DIM_W-1:0]    exp_height, exp_width;
  logic                exp_rsp_valid, exp_rsp_strike;
  logic [DIM_W-1:0]    exp_rsp_height, exp_rsp_width;
  logic [IDX_W-1:0]    exp_rsp_x, exp_rsp_y;
  logic [STRIKE_W-1:0] prev_strike;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h at edge %0d", tag, observed, expected, edge_n);
    end
  endtask

  task automatic reportTimeout(input string tag);
    checks++;
    errors++;
    $error("[TB] FAIL %s observed=timeout expected=completion", tag);
  endtask

  task automatic modelClear();
    fifo_q.delete();
    flight_q.delete();
    edge_n         = 0;
    exp_height     = '0;
    exp_width      = '0;
    exp_rsp_valid  = 1'b0;
    exp_rsp_height = '0;
    exp_rsp_width  = '0;
    exp_rsp_x      = '0;
    exp_rsp_y      = '0;
    exp_rsp_strike = 1'b0;
    prev_strike    = '0;
  endtask

  // Reference behaviour for one rising edge, using the inputs present at it.
  task automatic modelEdge();
    bit      acc;
    bit      is_issue;
    req_t    r;
    flight_t f;
    edge_n++;
    acc      = req_valid && (fifo_q.size() < FIFO_DEPTH);
    is_issue = (edge_n % SLOT_CYCLES) == 0;
    exp_rsp_valid = 1'b0;
    if (is_issue) begin
      if (flight_q.size() > 0 && flight_q[0].due == edge_n) begin
        f = flight_q.pop_front();
        exp_rsp_valid  = 1'b1;
        exp_rsp_height = f.h;
        exp_rsp_width  = f.w;
        exp_rsp_x      = index_x;
        exp_rsp_y      = index_y;
        exp_rsp_strike = (strike != prev_strike);
      end
      prev_strike = strike;
      if (fifo_q.size() > 0) begin
        r = fifo_q.pop_front();
        exp_height = r.h;
        exp_width  = r.w;
        f.due = edge_n + SLOT_CYCLES * LAT_SLOTS;
        f.h   = r.h;
        f.w   = r.w;
        flight_q.push_back(f);
      end else begin
        exp_height = '0;
        exp_width  = '0;
      end
    end
    if (acc && req_height != 0 && req_width != 0) begin
      r.h = req_height;
      r.w = req_width;
      fifo_q.push_back(r);
    end
    last_acc = acc;
  endtask

  task automatic checkAll();
    checkOutput("req_ready",  32'(req_ready),  32'(fifo_q.size() < FIFO_DEPTH));
    checkOutput("fifo_count", 32'(fifo_count), 32'(fifo_q.size()));
    checkOutput("height",     32'(height),     32'(exp_height));
    checkOutput("width",      32'(width),      32'(exp_width));
    checkOutput("rsp_valid",  32'(rsp_valid),  32'(exp_rsp_valid));
    checkOutput("rsp_height", 32'(rsp_height), 32'(exp_rsp_height));
    checkOutput("rsp_width",  32'(rsp_width),  32'(exp_rsp_width));
    checkOutput("rsp_x",      32'(rsp_index_x), 32'(exp_rsp_x));
    checkOutput("rsp_y",      32'(rsp_index_y), 32'(exp_rsp_y));
    checkOutput("rsp_strike", 32'(rsp_strike), 32'(exp_rsp_strike));
  endtask

  // One clock: drive at the falling edge, model at the rising edge, check 1 unit later.
  task automatic applyStimulus(input logic v, input logic [DIM_W-1:0] h, input logic [DIM_W-1:0] w);
    req_valid  = v;
    req_height = h;
    req_width  = w;
    @(posedge clk);
    modelEdge();
    #1;
    checkAll();
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) applyStimulus(1'b0, '0, '0);
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic applyReset();
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("rst_ready",      32'(req_ready),   32'd0);
    checkOutput("rst_fifo_count", 32'(fifo_count),  32'd0);
    checkOutput("rst_height",     32'(height),      32'd0);
    checkOutput("rst_width",      32'(width),       32'd0);
    checkOutput("rst_rsp_valid",  32'(rsp_valid),   32'd0);
    checkOutput("rst_rsp_height", 32'(rsp_height),  32'd0);
    checkOutput("rst_rsp_width",  32'(rsp_width),   32'd0);
    checkOutput("rst_rsp_x",      32'(rsp_index_x), 32'd0);
    checkOutput("rst_rsp_y",      32'(rsp_index_y), 32'd0);
    checkOutput("rst_rsp_strike", 32'(rsp_strike),  32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelClear();
  endtask

  initial begin
    int sent;
    int guard;
    bit found;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_height = '0;
    req_width  = '0;
    index_x    = '0;
    index_y    = '0;
    strike     = '0;
    modelClear();
    @(negedge clk);
    applyReset();

    // Single request ahead of the first issue edge.
    $display("[TB] single request");
    applyStimulus(1'b1, 5'd4, 5'd6);
    idle(2);
    checkOutput("tp1_height_pre", 32'(height), 32'd0);
    idle(1);
    checkOutput("tp1_height", 32'(height), 32'd4);
    checkOutput("tp1_width",  32'(width),  32'd6);
    idle(4);
    checkOutput("tp1_bubble_h", 32'(height), 32'd0);
    idle(4);
    checkOutput("tp1_rsp_valid",  32'(rsp_valid),  32'd1);
    checkOutput("tp1_rsp_height", 32'(rsp_height), 32'd4);
    checkOutput("tp1_rsp_width",  32'(rsp_width),  32'd6);
    checkOutput("tp1_rsp_strike", 32'(rsp_strike), 32'd0);
    idle(1);
    checkOutput("tp1_rsp_pulse", 32'(rsp_valid), 32'd0);

    // Burst of six with valid held, starting right after an issue edge.
    $display("[TB] burst");
    guard = 0;
    while ((edge_n % SLOT_CYCLES) != 0 && guard < 8) begin
      idle(1);
      guard++;
    end
    sent  = 0;
    guard = 0;
    while (sent < 6 && guard < 60) begin
      index_x = 8'(10 + guard);
      index_y = 8'(100 + guard);
      applyStimulus(1'b1, 5'(sent + 1), 5'(sent + 9));
      if (last_acc) sent++;
      guard++;
    end
    if (sent < 6) reportTimeout("burst_accept");

    // Drain with strike steps, including a 15 -> 0 wrap.
    for (int k = 0; k < 32; k++) begin
      if (k == 3)  strike = 4'd1;
      if (k == 9)  strike = 4'd15;
      if (k == 17) strike = 4'd0;
      index_x = 8'($urandom);
      index_y = 8'($urandom);
      applyStimulus(1'b0, '0, '0);
    end

    // Zero-dimension requests are swallowed.
    $display("[TB] zero-dimension requests");
    applyStimulus(1'b1, 5'd0, 5'd7);
    applyStimulus(1'b1, 5'd3, 5'd0);
    checkOutput("zero_fifo_count", 32'(fifo_count), 32'd0);
    idle(16);

    // Two requests separated by an empty slot.
    $display("[TB] bubble slot");
    applyStimulus(1'b1, 5'd2, 5'd3);
    idle(7);
    applyStimulus(1'b1, 5'd5, 5'd1);
    idle(20);

    // Reset two cycles after a piece is issued.
    $display("[TB] mid-operation reset");
    applyStimulus(1'b1, 5'd7, 5'd7);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      idle(1);
      if ((edge_n % SLOT_CYCLES) == 0 && exp_height == 5'd7) found = 1'b1;
    end
    if (!found) reportTimeout("midrst_issue");
    idle(2);
    applyReset();
    idle(16);

    // Randomized traffic.
    $display("[TB] random phase");
    for (int k = 0; k < 300; k++) begin
      logic [DIM_W-1:0] rh;
      logic [DIM_W-1:0] rw;
      rh = 5'($urandom);
      rw = 5'($urandom);
      if ($urandom_range(0, 9) == 0) rh = '0;
      if ($urandom_range(0, 9) == 0) rw = '0;
      index_x = 8'($urandom);
      index_y = 8'($urandom);
      if ($urandom_range(0, 5) == 0) strike = strike + 4'd1;
      applyStimulus(1'($urandom_range(0, 1)), rh, rw);
    end
    idle(16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/placement_request_sequencer.md
# placement_request_sequencer

Front-end driver for the sticker-placement core. Accepts placement requests from upstream over a valid/ready handshake, buffers them, and drives `height_i`/`width_i` of `M216A_TopModule` on the core's fixed 4-cycle issue cadence. Two slots later it captures the core's `index_x_o`/`index_y_o`/`strike_o` and returns a tagged response that pairs each placement result with the request that produced it. It is the producing end of the core's input stream and the consuming end of its result stream.

## Interface
Parameters:
- `DIM_W`, default 5: height/width field width.
- `IDX_W`, default 8: placement index width.
- `STRIKE_W`, default 4: core strike counter width.
- `FIFO_DEPTH`, default 4: request buffer entries; must be a power of 2.
- `SLOT_CYCLES`, default 4: clock cycles per issue slot.
- `LAT_SLOTS`, default 2: core result latency in slots (8 cycles).

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  reset, asynchronous and active-high.
- `req_valid_i`  in  1  upstream request valid.
- `req_ready_o`  out  1  buffer can accept a request.
- `req_height_i`  in  DIM_W  request height.
- `req_width_i`  in  DIM_W  request width.
- `height_o`  out  DIM_W  to core `height_i`.
- `width_o`  out  DIM_W  to core `width_i`.
- `index_x_i`  in  IDX_W  from core `index_x_o`.
- `index_y_i`  in  IDX_W  from core `index_y_o`.
- `strike_i`  in  STRIKE_W  from core `strike_o`.
- `rsp_valid_o`  out  1  one-cycle response pulse.
- `rsp_height_o`, `rsp_width_o`  out  DIM_W  echoed request.
- `rsp_index_x_o`, `rsp_index_y_o`  out  IDX_W  captured placement.
- `rsp_strike_o`  out  1  core strike count changed for this piece.
- `fifo_count_o`  out  log2(FIFO_DEPTH)+1  buffered entries.

## Operation
- Reset value of all outputs and state is 0. Exception: `req_ready_o` is 1 when reset is deasserted.
- Slot counter:
  - Runs 0..SLOT_CYCLES-1 continuously, starting from 0 at reset release.
  - An issue edge is the rising edge at which the counter is SLOT_CYCLES-1 (wraps to 0).
- Push:
  - A request is accepted when `req_valid_i && req_ready_o`.
  - A request with height 0 or width 0 is accepted but discarded: no FIFO write and no response.
- `req_ready_o` is `fifo_count < FIFO_DEPTH`, registered-count based.
  - When the FIFO is full, push is refused even if a pop occurs on the same edge.
  - When the FIFO is not full, a simultaneous push and pop leaves the count unchanged.
- Issue edge:
  - If the FIFO is non-empty, pop the head into `height_o`/`width_o`.
  - If the FIFO is empty, drive 0/0 (bubble). 0/0 is the core's no-op code.
  - `height_o`/`width_o` are held stable for the whole slot.
- Tag pipeline: a LAT_SLOTS-deep shift register of {valid, h, w}, advanced on each issue edge. A bubble enters with valid=0.
- Capture, on each issue edge, when the tag leaving the pipeline has valid=1:
  - Register `index_x_i`, `index_y_i`, and the tag's h/w into the `rsp_*` outputs.
  - Set `rsp_strike_o = (strike_i != strike_prev)`.
  - Assert `rsp_valid_o` for exactly one cycle.
- `strike_prev` updates on every issue edge, bubbles included. Comparison is inequality, so a 4-bit wrap still flags a strike.
- Bubbles produce no response, and `rsp_*` data holds its last value.

## Timing
- The first issue edge is the 4th rising edge after reset release. Issue edges then occur every 4 edges.
- Request-to-issue: at least 1 cycle (a request registered before the issue edge is popped at it), at most (queue position+1)×4 cycles.
- Issue-to-response: a piece issued at edge E is captured at edge E+8. `rsp_valid_o` is high during the cycle after E+8.
- Peak throughput: 1 response per 4 cycles. Sustained back-pressure keeps `req_ready_o` low until the next issue edge.
- `rst_i` asserted mid-operation:
  - Immediately clears the FIFO, tags, slot counter, `strike_prev`, and all outputs.
  - In-flight requests are lost; no partial response is emitted.
- `fifo_count_o` updates on the edge following the push/pop.

## Test plan
- Reset, then push one request h=4 w=6 before the first issue edge -> `height_o`=4, `width_o`=6 from edge 4 for 4 cycles, then 0/0. With `index_x_i`=0, `index_y_i`=0 at edge 12: `rsp_valid_o` pulses with h=4 w=6 x=0 y=0 `rsp_strike_o`=0.
- Burst-push 6 requests with `req_valid_i` held high -> 4 accepted, `req_ready_o` drops, `fifo_count_o`=4. One more is accepted after each issue edge. Responses arrive in order, 4 cycles apart.
- `strike_i` steps 0->1 at the capture of the 2nd piece -> only the 2nd response has `rsp_strike_o`=1. A step 15->0 also flags 1.
- Push h=0 w=7 and h=3 w=0 -> both accepted, no issue, `height_o`/`width_o` stay 0/0, no `rsp_valid_o`.
- Two requests separated by an empty slot -> bubble slot drives 0/0. Responses arrive 8 cycles apart with no spurious pulse between them.
- Assert `rst_i` 2 cycles after the issue of a queued piece -> all outputs 0 immediately, `fifo_count_o`=0, and no response for that piece after release.
